// File: rtl/counter_frame_pkg.sv
// Shared tags, widths and FSM state type for the counter frame receiver.
// Imported by counter_frame_rx.
package counter_frame_pkg;

    localparam int unsigned TAG_W     = 3;
    localparam int unsigned PAYLOAD_W = 5;
    localparam int unsigned FRAME_W   = 17;

    localparam logic [TAG_W-1:0] TAG_B0 = 3'b000;
    localparam logic [TAG_W-1:0] TAG_B1 = 3'b001;
    localparam logic [TAG_W-1:0] TAG_B2 = 3'b010;
    localparam logic [TAG_W-1:0] TAG_B3 = 3'b011;

    // StIdx0 is the hunt state; StIdxN waits for byte N of the frame.
    typedef enum logic [1:0] {
        StIdx0,
        StIdx1,
        StIdx2,
        StIdx3
    } rx_state_e;

endpackage

// File: rtl/counter_frame_timer.sv
// Idle-gap timer: counts cycles without a byte while a frame is open and
// strobes timeout on the cycle the count reaches TIMEOUT_CYCLES (0 disables).
module counter_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic byte_valid,
    output logic timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_q;

    always_ff @(posedge clock) begin
        if (reset || byte_valid || !active) begin
            idle_q <= '0;
        end else if (idle_q != CNT_MAX) begin
            idle_q <= idle_q + CNT_W'(1);
        end
    end

    // A byte in the expiring cycle suppresses the timeout.
    assign timeout = (TIMEOUT_CYCLES != 0) && active && !byte_valid && (idle_q == CNT_LAST);

endmodule

// File: rtl/counter_frame_rx.sv
// Four-byte tagged frame receiver decoding a 16-bit count and a reset flag.
// Optional sequence checking is enabled by defining COUNTER_FRAME_RX_SEQ_CHECK_EN.
module counter_frame_rx
    import counter_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] count_out,
    output logic        reset_flag,
    output logic        count_valid,
    output logic        frame_err,
    output logic        seq_err,
    output logic        busy
);

    logic [TAG_W-1:0]       tag;
    logic [PAYLOAD_W-1:0]   payload;
    logic [3*PAYLOAD_W-1:0] word_q;
    logic [FRAME_W-1:0]     frame_word;

    rx_state_e   state_q, state_d;
    logic        timeout;
    logic        good_frame;
    logic        bad_frame;
    logic [15:0] count_q, count_d;
    logic        flag_q, flag_d;
    logic        count_valid_q;
    logic        frame_err_q;

    assign tag        = rx_data[7:5];
    assign payload    = rx_data[4:0];
    assign frame_word = {payload[1:0], word_q};

    counter_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .active    (busy),
        .byte_valid(rx_valid),
        .timeout   (timeout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdx0;
            count_q       <= '0;
            flag_q        <= 1'b0;
            count_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            flag_q        <= flag_d;
            count_valid_q <= good_frame;
            frame_err_q   <= bad_frame;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        if (timeout) begin
            state_d   = StIdx0;
            bad_frame = 1'b1;
        end else if (rx_valid) begin
            // Unexpected byte by default; a byte0 tag always restarts the frame.
            state_d   = (tag == TAG_B0) ? StIdx1 : StIdx0;
            bad_frame = 1'b1;
            unique case (state_q)
                StIdx0: bad_frame = (tag != TAG_B0);
                StIdx1: begin
                    if (tag == TAG_B1) begin
                        state_d   = StIdx2;
                        bad_frame = 1'b0;
                    end
                end
                StIdx2: begin
                    if (tag == TAG_B2) begin
                        state_d   = StIdx3;
                        bad_frame = 1'b0;
                    end
                end
                StIdx3: begin
                    if (tag == TAG_B3 && payload[4:2] == 3'b000) begin
                        good_frame = 1'b1;
                        bad_frame  = 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        flag_d  = flag_q;
        if (good_frame) begin
            {count_d, flag_d} = frame_word;
        end
    end

    assign busy        = (state_q != StIdx0);
    assign count_out   = count_q;
    assign reset_flag  = flag_q;
    assign count_valid = count_valid_q;
    assign frame_err   = frame_err_q;

    always_ff @(posedge clock) begin
        if (rx_valid) begin
            if (tag == TAG_B0) begin
                word_q[4:0] <= payload;
            end
            if (state_q == StIdx1 && tag == TAG_B1) begin
                word_q[9:5] <= payload;
            end
            if (state_q == StIdx2 && tag == TAG_B2) begin
                word_q[14:10] <= payload;
            end
        end
    end

`ifdef COUNTER_FRAME_RX_SEQ_CHECK_EN
    logic hist_valid_q;
    logic seq_err_q, seq_err_d;

    // count_q still holds the previous good count when the new frame completes.
    always_comb begin
        seq_err_d = good_frame && hist_valid_q && !frame_word[0] &&
                    (frame_word[16:1] != count_q + 16'd1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_valid_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            seq_err_q <= seq_err_d;
            if (good_frame) begin
                hist_valid_q <= 1'b1;
            end
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_frame_rx.sv
// Self-checking bench for counter_frame_rx: table of bytes with expected pulses,
// a scoreboard queue of expected events, and directed timeout/reset sequences.
module tb_counter_frame_rx;

`ifdef COUNTER_FRAME_RX_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    typedef enum logic [1:0] {EvNone, EvGood, EvErr} ev_e;

    typedef struct {
        logic        vld;
        logic [7:0]  data;
        ev_e         ev;
        logic [15:0] cnt;
        logic        flag;
        logic        seq;
        logic        bsy;
    } vec_t;

    typedef struct {
        int unsigned cyc;
        ev_e         ev;
        logic [15:0] cnt;
        logic        flag;
        logic        seq;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] count_out;
    logic        reset_flag;
    logic        count_valid;
    logic        frame_err;
    logic        seq_err;
    logic        busy;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs[$];
    exp_t        exp_q[$];
    exp_t        mon_e;

    counter_frame_rx #(
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .count_out  (count_out),
        .reset_flag (reset_flag),
        .count_valid(count_valid),
        .frame_err  (frame_err),
        .seq_err    (seq_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void add(input logic vld, input logic [7:0] d, input ev_e ev,
                                input logic [15:0] c, input logic f, input logic s,
                                input logic b);
        vec_t v;
        v.vld  = vld;
        v.data = d;
        v.ev   = ev;
        v.cnt  = c;
        v.flag = f;
        v.seq  = s;
        v.bsy  = b;
        vecs.push_back(v);
    endfunction

    // Called just after a rising edge; the byte is consumed by the next edge.
    task automatic send(input logic vld, input logic [7:0] d, input ev_e ev,
                        input logic [15:0] c, input logic f, input logic s, input logic b);
        exp_t e;
        rx_valid = vld;
        rx_data  = d;
        if (ev != EvNone) begin
            e.cyc  = cyc + 1;
            e.ev   = ev;
            e.cnt  = c;
            e.flag = f;
            e.seq  = s & SEQ_EN;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        chk1("busy", busy, b);
    endtask

    // Scoreboard: every pulse must match the head of the expected queue.
    always @(negedge clock) begin
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            chk1("count_valid", count_valid, mon_e.ev == EvGood);
            chk1("frame_err", frame_err, mon_e.ev == EvErr);
            chk1("seq_err", seq_err, mon_e.seq);
            chk16("count_out", count_out, mon_e.cnt);
            chk1("reset_flag", reset_flag, mon_e.flag);
        end else if (count_valid === 1'b1 || frame_err === 1'b1 || seq_err === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse at cycle %0d: got cv=%b fe=%b se=%b expected none",
                     cyc, count_valid, frame_err, seq_err);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Good frames, rebasing, wrap-around, and a frame with idle gaps.
        add(1, 8'h08, EvNone, 0, 0, 0, 1); add(1, 8'h23, EvNone, 0, 0, 0, 1);
        add(1, 8'h49, EvNone, 0, 0, 0, 1); add(1, 8'h60, EvGood, 16'h1234, 0, 0, 0);
        add(1, 8'h01, EvNone, 0, 0, 0, 1); add(1, 8'h20, EvNone, 0, 0, 0, 1);
        add(1, 8'h40, EvNone, 0, 0, 0, 1); add(1, 8'h60, EvGood, 16'h0000, 1, 0, 0);
        add(1, 8'h1E, EvNone, 0, 0, 0, 1); add(1, 8'h3F, EvNone, 0, 0, 0, 1);
        add(1, 8'h5F, EvNone, 0, 0, 0, 1); add(1, 8'h63, EvGood, 16'hFFFF, 0, 1, 0);
        add(1, 8'h00, EvNone, 0, 0, 0, 1); add(1, 8'h20, EvNone, 0, 0, 0, 1);
        add(1, 8'h40, EvNone, 0, 0, 0, 1); add(1, 8'h60, EvGood, 16'h0000, 0, 0, 0);
        add(1, 8'h02, EvNone, 0, 0, 0, 1); add(0, 8'h00, EvNone, 0, 0, 0, 1);
        add(0, 8'h00, EvNone, 0, 0, 0, 1); add(1, 8'h20, EvNone, 0, 0, 0, 1);
        add(1, 8'h40, EvNone, 0, 0, 0, 1); add(0, 8'h00, EvNone, 0, 0, 0, 1);
        add(1, 8'h60, EvGood, 16'h0001, 0, 0, 0);
        // Wrong tag in IDX1 then recovery.
        add(1, 8'h08, EvNone, 0, 0, 0, 1); add(1, 8'h49, EvErr, 16'h0001, 0, 0, 0);
        add(1, 8'h08, EvNone, 0, 0, 0, 1); add(1, 8'h23, EvNone, 0, 0, 0, 1);
        add(1, 8'h49, EvNone, 0, 0, 0, 1); add(1, 8'h60, EvGood, 16'h1234, 0, 1, 0);
        // Tag 000 in IDX2 restarts the frame.
        add(1, 8'h08, EvNone, 0, 0, 0, 1); add(1, 8'h23, EvNone, 0, 0, 0, 1);
        add(1, 8'h08, EvErr, 16'h1234, 0, 0, 1); add(1, 8'h23, EvNone, 0, 0, 0, 1);
        add(1, 8'h49, EvNone, 0, 0, 0, 1); add(1, 8'h60, EvGood, 16'h1234, 0, 1, 0);
        // Illegal tags, stray tags in IDX0.
        add(1, 8'h88, EvErr, 16'h1234, 0, 0, 0); add(1, 8'h23, EvErr, 16'h1234, 0, 0, 0);
        add(1, 8'h08, EvNone, 0, 0, 0, 1); add(1, 8'hA3, EvErr, 16'h1234, 0, 0, 0);
        // Tag 000 in IDX3 restarts the frame.
        add(1, 8'h08, EvNone, 0, 0, 0, 1); add(1, 8'h23, EvNone, 0, 0, 0, 1);
        add(1, 8'h49, EvNone, 0, 0, 0, 1); add(1, 8'h08, EvErr, 16'h1234, 0, 0, 1);
        add(1, 8'h23, EvNone, 0, 0, 0, 1); add(1, 8'h49, EvNone, 0, 0, 0, 1);
        add(1, 8'h60, EvGood, 16'h1234, 0, 1, 0);
        // byte3 with nonzero upper payload bits.
        add(1, 8'h08, EvNone, 0, 0, 0, 1); add(1, 8'h23, EvNone, 0, 0, 0, 1);
        add(1, 8'h49, EvNone, 0, 0, 0, 1); add(1, 8'h64, EvErr, 16'h1234, 0, 0, 0);
        add(1, 8'h08, EvNone, 0, 0, 0, 1); add(1, 8'h23, EvNone, 0, 0, 0, 1);
        add(1, 8'h49, EvNone, 0, 0, 0, 1); add(1, 8'h7F, EvErr, 16'h1234, 0, 0, 0);
        // All-ones word (flag set), then a flag-clear frame breaking the sequence.
        add(1, 8'h08, EvNone, 0, 0, 0, 1); add(1, 8'h23, EvNone, 0, 0, 0, 1);
        add(1, 8'h1F, EvErr, 16'h1234, 0, 0, 1); add(1, 8'h3F, EvNone, 0, 0, 0, 1);
        add(1, 8'h5F, EvNone, 0, 0, 0, 1); add(1, 8'h63, EvGood, 16'hFFFF, 1, 0, 0);
        add(1, 8'h01, EvNone, 0, 0, 0, 1); add(1, 8'h20, EvNone, 0, 0, 0, 1);
        add(1, 8'h40, EvNone, 0, 0, 0, 1); add(1, 8'h60, EvGood, 16'h0000, 1, 0, 0);
        add(1, 8'h00, EvNone, 0, 0, 0, 1); add(1, 8'h20, EvNone, 0, 0, 0, 1);
        add(1, 8'h40, EvNone, 0, 0, 0, 1); add(1, 8'h60, EvGood, 16'h0000, 0, 1, 0);

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        chk16("reset_count_out", count_out, 16'h0000);
        chk1("reset_reset_flag", reset_flag, 1'b0);
        chk1("reset_count_valid", count_valid, 1'b0);
        chk1("reset_frame_err", frame_err, 1'b0);
        chk1("reset_seq_err", seq_err, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            send(vecs[i].vld, vecs[i].data, vecs[i].ev, vecs[i].cnt, vecs[i].flag,
                 vecs[i].seq, vecs[i].bsy);
        end

        // Timeout after 255 idle cycles mid-frame.
        send(1, 8'h08, EvNone, 0, 0, 0, 1);
        send(1, 8'h23, EvNone, 0, 0, 0, 1);
        for (int i = 0; i < 254; i++) send(0, 8'h00, EvNone, 0, 0, 0, 1);
        send(0, 8'h00, EvErr, 16'h0000, 0, 0, 0);
        send(0, 8'h00, EvNone, 0, 0, 0, 0);

        // A byte arriving on the expiring cycle wins over the timeout.
        send(1, 8'h08, EvNone, 0, 0, 0, 1);
        send(1, 8'h23, EvNone, 0, 0, 0, 1);
        for (int i = 0; i < 254; i++) send(0, 8'h00, EvNone, 0, 0, 0, 1);
        send(1, 8'h49, EvNone, 0, 0, 0, 1);
        send(1, 8'h60, EvGood, 16'h1234, 0, 1, 0);

        // Reset mid-frame: partial frame dropped silently, bytes during reset ignored.
        send(1, 8'h08, EvNone, 0, 0, 0, 1);
        send(1, 8'h23, EvNone, 0, 0, 0, 1);
        reset = 1'b1;
        send(1, 8'h49, EvNone, 0, 0, 0, 0);
        send(1, 8'h60, EvNone, 0, 0, 0, 0);
        reset = 1'b0;
        chk16("midreset_count_out", count_out, 16'h0000);
        chk1("midreset_reset_flag", reset_flag, 1'b0);
        send(1, 8'h08, EvNone, 0, 0, 0, 1);
        send(1, 8'h23, EvNone, 0, 0, 0, 1);
        send(1, 8'h49, EvNone, 0, 0, 0, 1);
        send(1, 8'h60, EvGood, 16'h1234, 0, 0, 0);

        repeat (3) send(0, 8'h00, EvNone, 0, 0, 0, 0);
        chk16("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
